// File: rtl/dpram_arb_pkg.sv
// Shared types and defaults for the dual-port RAM arbiter.
// Provides req_id_t for last-winner tracking and width defaults.
package dpram_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam int ADDR_WIDTH_D = 9;
  localparam int DATA_WIDTH_D = 32;

endpackage

// File: rtl/dpram_arb_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit last-winner register.
// Ports: clk, rst (async high), req[1:0] (0=A,1=B), gnt[1:0] (combinational).
module rr_arb2
  import dpram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // contention: whoever did not win last time
        2'b11:   gnt = (last == REQ_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= REQ_B;
    end else if (gnt[0]) begin
      last <= REQ_A;
    end else if (gnt[1]) begin
      last <= REQ_B;
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Arbitrates requesters A and B onto one 1R1W SRAM, read/write independent.
// Ports: a_/b_ request sides, m_ RAM side, rd shared read data.
// Optional DPRAM_ARB_BYPASS_EN forwards same-cycle same-address writes to rd.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_ract,
  input  logic                  b_ract,
  input  logic [ADDR_WIDTH-1:0] a_ra,
  input  logic [ADDR_WIDTH-1:0] b_ra,
  output logic                  a_rgnt,
  output logic                  b_rgnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rd,
  input  logic                  a_wact,
  input  logic                  b_wact,
  input  logic [ADDR_WIDTH-1:0] a_wa,
  input  logic [ADDR_WIDTH-1:0] b_wa,
  input  logic [DATA_WIDTH-1:0] a_wdw,
  input  logic [DATA_WIDTH-1:0] b_wdw,
  output logic                  a_wgnt,
  output logic                  b_wgnt,
  output logic                  m_ract,
  output logic [ADDR_WIDTH-1:0] m_ra,
  input  logic [DATA_WIDTH-1:0] m_rdr,
  output logic                  m_wact,
  output logic [ADDR_WIDTH-1:0] m_wa,
  output logic [DATA_WIDTH-1:0] m_wdw
);

  logic [1:0] rgnt;
  logic [1:0] wgnt;

  rr_arb2 u_rarb (
    .clk (clk),
    .rst (rst),
    .req ({b_ract, a_ract}),
    .gnt (rgnt)
  );

  rr_arb2 u_warb (
    .clk (clk),
    .rst (rst),
    .req ({b_wact, a_wact}),
    .gnt (wgnt)
  );

  assign a_rgnt = rgnt[0];
  assign b_rgnt = rgnt[1];
  assign a_wgnt = wgnt[0];
  assign b_wgnt = wgnt[1];
  assign m_ract = |rgnt;
  assign m_wact = |wgnt;

  always_comb begin
    m_ra  = '0;
    m_wa  = '0;
    m_wdw = '0;
    unique case (1'b1)
      rgnt[0]: m_ra = a_ra;
      rgnt[1]: m_ra = b_ra;
      default: m_ra = '0;
    endcase
    unique case (1'b1)
      wgnt[0]: begin
        m_wa  = a_wa;
        m_wdw = a_wdw;
      end
      wgnt[1]: begin
        m_wa  = b_wa;
        m_wdw = b_wdw;
      end
      default: begin
        m_wa  = '0;
        m_wdw = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= rgnt[0];
      b_rvalid <= rgnt[1];
    end
  end

`ifdef DPRAM_ARB_BYPASS_EN
  logic                  hit;
  logic [DATA_WIDTH-1:0] byp;

  // RAM is read-before-write; capture the colliding write to forward it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit <= 1'b0;
      byp <= '0;
    end else begin
      hit <= m_ract && m_wact && (m_ra == m_wa);
      byp <= m_wdw;
    end
  end

  assign rd = hit ? byp : m_rdr;
`else
  assign rd = m_rdr;
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Scoreboard bench for dpram_arbiter with a behavioural RAM and model.
// Stimulus pushes expected reads; a monitor pops them on rvalid.
module tb_dpram_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_ract, b_ract;
  logic [AW-1:0] a_ra, b_ra;
  logic          a_rgnt, b_rgnt;
  logic          a_rvalid, b_rvalid;
  logic [DW-1:0] rd;
  logic          a_wact, b_wact;
  logic [AW-1:0] a_wa, b_wa;
  logic [DW-1:0] a_wdw, b_wdw;
  logic          a_wgnt, b_wgnt;
  logic          m_ract, m_wact;
  logic [AW-1:0] m_ra, m_wa;
  logic [DW-1:0] m_rdr, m_wdw;

  int checks = 0;
  int errors = 0;

  dpram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_ract   (a_ract),
    .b_ract   (b_ract),
    .a_ra     (a_ra),
    .b_ra     (b_ra),
    .a_rgnt   (a_rgnt),
    .b_rgnt   (b_rgnt),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid),
    .rd       (rd),
    .a_wact   (a_wact),
    .b_wact   (b_wact),
    .a_wa     (a_wa),
    .b_wa     (b_wa),
    .a_wdw    (a_wdw),
    .b_wdw    (b_wdw),
    .a_wgnt   (a_wgnt),
    .b_wgnt   (b_wgnt),
    .m_ract   (m_ract),
    .m_ra     (m_ra),
    .m_rdr    (m_rdr),
    .m_wact   (m_wact),
    .m_wa     (m_wa),
    .m_wdw    (m_wdw)
  );

  always #5 clk = ~clk;

  // harness RAM: synchronous read-before-write
  logic [DW-1:0] ram [512];
  always @(posedge clk) begin
    if (m_ract) m_rdr <= ram[m_ra];
    if (m_wact) ram[m_wa] <= m_wdw;
  end

  // reference model state
  logic [DW-1:0] mm [512];
  bit            rlast_b = 1'b1;
  bit            wlast_b = 1'b1;
  logic [DW:0]   sbq [$];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    a_ract = 0; b_ract = 0; a_wact = 0; b_wact = 0;
    a_ra = 0; b_ra = 0; a_wa = 0; b_wa = 0;
    a_wdw = 0; b_wdw = 0;
  endtask

  task automatic idle();
    @(negedge clk);
    clr();
  endtask

  // one cycle of stimulus; winner chosen from fairness rule
  task automatic cyc(input bit ar, input bit br,
                     input bit aw, input bit bw,
                     input logic [AW-1:0] ara,
                     input logic [AW-1:0] bra,
                     input logic [AW-1:0] awa,
                     input logic [AW-1:0] bwa,
                     input logic [DW-1:0] awd,
                     input logic [DW-1:0] bwd);
    logic [1:0]    rg, wg;
    logic [AW-1:0] ea, ewa;
    logic [DW-1:0] ewd, rdat;
    @(negedge clk);
    a_ract = ar; b_ract = br; a_wact = aw; b_wact = bw;
    a_ra = ara; b_ra = bra; a_wa = awa; b_wa = bwa;
    a_wdw = awd; b_wdw = bwd;
    #1;
    if (ar && br) rg = rlast_b ? 2'b01 : 2'b10;
    else          rg = {br, ar};
    if (aw && bw) wg = wlast_b ? 2'b01 : 2'b10;
    else          wg = {bw, aw};
    ea  = rg[0] ? ara : (rg[1] ? bra : '0);
    ewa = wg[0] ? awa : (wg[1] ? bwa : '0);
    ewd = wg[0] ? awd : (wg[1] ? bwd : '0);
    check("rgnt", {b_rgnt, a_rgnt}, rg);
    check("wgnt", {b_wgnt, a_wgnt}, wg);
    check("m_ract", m_ract, |rg);
    check("m_ra", m_ra, ea);
    check("m_wact", m_wact, |wg);
    check("m_wa", m_wa, ewa);
    check("m_wdw", m_wdw, ewd);
    if (|rg) begin
      rdat = mm[ea];
`ifdef DPRAM_ARB_BYPASS_EN
      if ((|wg) && ewa == ea) rdat = ewd;
`endif
      sbq.push_back({rg[1], rdat});
      rlast_b = rg[1];
    end
    if (|wg) begin
      mm[ewa] = ewd;
      wlast_b = wg[1];
    end
  endtask

  // monitor: pops one expected read per rvalid
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!rst && (a_rvalid || b_rvalid)) begin
      if (a_rvalid && b_rvalid) begin
        checks++;
        errors++;
        $display("FAIL rvalid_both: got 11 expected one-hot");
      end else if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_spurious: got a=%0b b=%0b expected none",
                 a_rvalid, b_rvalid);
      end else begin
        e = sbq.pop_front();
        check("rvalid_who", {b_rvalid, a_rvalid},
              e[DW] ? 2'b10 : 2'b01);
        check("rd", rd, e[DW-1:0]);
      end
    end
  end

  initial begin
    logic [DW:0] dummy;
    for (int i = 0; i < 512; i++) begin
      ram[i] = '0;
      mm[i]  = '0;
    end
    ram[5]  = 32'hDEADBEEF;
    mm[5]   = 32'hDEADBEEF;
    ram[16] = 32'h12345678;
    mm[16]  = 32'h12345678;

    // requests held during reset must see no grant
    rst = 1'b1;
    clr();
    a_ract = 1; b_ract = 1; a_wact = 1; b_wact = 1;
    repeat (2) @(negedge clk);
    check("rst_rgnt", {b_rgnt, a_rgnt}, 2'b00);
    check("rst_wgnt", {b_wgnt, a_wgnt}, 2'b00);
    check("rst_mact", {m_wact, m_ract}, 2'b00);
    check("rst_rvalid", {b_rvalid, a_rvalid}, 2'b00);
    clr();
    @(negedge clk);
    rst = 1'b0;

    // single read from A
    cyc(1, 0, 0, 0, 9'h005, 0, 0, 0, 0, 0);
    check("t1_a_rgnt", a_rgnt, 1'b1);
    idle();
    #1;
    check("t1_a_rvalid", a_rvalid, 1'b1);
    check("t1_b_rvalid", b_rvalid, 1'b0);
    check("t1_rd", rd, 32'hDEADBEEF);

    // sustained read contention
    for (int i = 0; i < 6; i++)
      cyc(1, 1, 0, 0, 9'h005, 9'h010, 0, 0, 0, 0);
    idle();

    // sustained write contention, then read back
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 1, 1, 0, 0, 9'h001, 9'h002, 32'h11, 32'h22);
    cyc(1, 0, 0, 0, 9'h001, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 9'h002, 0, 0, 0, 0, 0);
    idle();
    check("t3_mem1", mm[1], 32'h11);
    check("t3_mem2", mm[2], 32'h22);

    // same-address read/write collision
    cyc(0, 1, 1, 0, 0, 9'h010, 9'h010, 0, 32'hCAFE0000, 0);
    idle();
    #1;
`ifdef DPRAM_ARB_BYPASS_EN
    check("t4_rd", rd, 32'hCAFE0000);
`else
    check("t4_rd", rd, 32'h12345678);
`endif

    // reset right after a read grant loses the read
    cyc(1, 0, 0, 0, 9'h005, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    dummy = sbq.pop_back();
    rlast_b = 1'b1;
    wlast_b = 1'b1;
    @(negedge clk);
    check("t5_rvalid", {b_rvalid, a_rvalid}, 2'b00);
    check("t5_rgnt", {b_rgnt, a_rgnt}, 2'b00);
    clr();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 1, 1, 9'h003, 9'h004, 9'h007, 9'h008,
        32'hA0A0A0A0, 32'hB0B0B0B0);
    check("t5_first_r", {b_rgnt, a_rgnt}, 2'b01);
    check("t5_first_w", {b_wgnt, a_wgnt}, 2'b01);

    // B drops its request after losing one contended cycle
    idle();
    @(negedge clk);
    rst = 1'b1;
    rlast_b = 1'b1;
    wlast_b = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 0, 0, 9'h005, 9'h001, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 9'h002, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 9'h001, 9'h002, 0, 0, 0, 0);
    check("t6_rgnt", {b_rgnt, a_rgnt}, 2'b10);
    idle();

    // randomized traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1),
          AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
          AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
          $urandom, $urandom);
    end
    repeat (3) idle();
    check("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
